mmt_feeder: RTL and testbench
=============================

MMT_FEEDER -- requirements
Module: mmt_feeder

Interface
REQ-001 Port clk, input, 1: sole clock; all state on rising edge.
REQ-002 Port rst_n, input, 1: asynchronous active-low reset.
REQ-003 Port start, input, 1: begin a matrix-load session; sampled only in IDLE.
REQ-004 Port cfg_size, input, 2: 0=2x2, 1=4x4, 2=8x8, 3=16x16; latched when start is accepted.
REQ-005 Port s_valid/s_data/s_ready, input 1 / input 8 / output 1: upstream element stream, valid/ready handshake.
REQ-006 Port cmd_valid/cmd_mode/cmd_idx_a/cmd_idx_b/cmd_idx_c/cmd_ready, in 1/in 2/in 5/in 5/in 5/out 1: upstream compute command.
REQ-007 Port in_valid, output, 1; matrix, output, 8; matrix_size, output, 2: matrix-load stream to MMT.
REQ-008 Port in_valid2, output, 1; matrix_idx, output, 5; mode, output, 2: command stream to MMT.
REQ-009 Port out_valid, input, 1: MMT result-valid, used only to detect result completion.
REQ-010 Port busy, output, 1; err, output, 1; res_count, output, 8: status.

Function
REQ-011 States SHALL be IDLE, LOAD, CMD_WAIT, ISSUE, WAIT_RES.
REQ-012 IDLE: start=1 -> LOAD next cycle; cfg_size latched; err cleared; res_count cleared.
REQ-013 LOAD: s_ready=1; element total = 16*N*N (64/256/1024/4096); counter width 12 bits, counts accepted elements.
REQ-014 Each accepted element (s_valid&s_ready at cycle t) SHALL appear as in_valid=1, matrix=s_data at t+1 (one-cycle registered latency).
REQ-015 matrix_size SHALL equal latched cfg_size only on the first in_valid cycle of a session; 0 otherwise.
REQ-016 Before the first element, s_valid=0 is allowed (wait indefinitely, in_valid=0).
REQ-017 After the first element, s_valid=0 in LOAD is a protocol gap: abort to IDLE, err=1 (sticky until next accepted start), in_valid=0 that cycle, s_ready=0 next cycle.
REQ-018 After the last element is accepted: s_ready=0 the following cycle, state -> CMD_WAIT.
REQ-019 CMD_WAIT: cmd_ready=1; on cmd_valid&cmd_ready, latch mode and three indices, -> ISSUE.
REQ-020 ISSUE: in_valid2=1 for exactly 3 consecutive cycles, starting the cycle after acceptance; matrix_idx = idx_a, idx_b, idx_c in order; mode = cmd_mode on the first cycle only, 0 on the other two; then -> WAIT_RES.
REQ-021 WAIT_RES: wait for out_valid=1, then for out_valid=0; on that falling edge res_count increments (wraps 255->0) and state -> CMD_WAIT next cycle.
REQ-022 out_valid activity outside WAIT_RES SHALL be ignored.
REQ-023 When not asserted, in_valid/in_valid2 are 0 and matrix/matrix_size/matrix_idx/mode are 0.
REQ-024 cmd_ready is 0 in every state except CMD_WAIT; s_ready is 0 in every state except LOAD.
REQ-025 start in any state other than IDLE SHALL be ignored; returning to IDLE from CMD_WAIT occurs only via start=1 with cmd_valid=0 (new session; start wins if simultaneous is not allowed: cmd_valid has priority).
REQ-026 busy=1 in LOAD, ISSUE, WAIT_RES; 0 in IDLE and CMD_WAIT.
REQ-027 in_valid and in_valid2 SHALL never be 1 in the same cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, all outputs 0, counters 0, err 0, regardless of activity.
REQ-029 Reset mid-LOAD or mid-ISSUE SHALL truncate the stream with no further in_valid/in_valid2 after release until a new start.

Verification
REQ-030 cfg_size=0, start, 64 contiguous bytes 0..63 -> in_valid high 64 cycles, matrix 0..63, matrix_size=0 first cycle, then cmd_ready=1.
REQ-031 cfg_size=3, 4096 bytes with 5 idle cycles before the first -> in_valid exactly 4096 contiguous cycles, matrix_size=3 on first only, err=0.
REQ-032 cfg_size=1, s_valid dropped after element 10 -> in_valid 10 cycles, err=1, state IDLE; new start clears err.
REQ-033 In CMD_WAIT, cmd mode=2, idx 3/7/15 -> in_valid2 3 cycles, matrix_idx 3,7,15, mode 2,0,0; out_valid pulse 4 cycles -> res_count=1, cmd_ready=1 next cycle.
REQ-034 rst_n pulsed during ISSUE second cycle -> all outputs 0 immediately, no third in_valid2, res_count=0.
REQ-035 256 command/result rounds -> res_count wraps to 0; start asserted during WAIT_RES has no effect.

Source files
------------

// File: rtl/mmt_feeder_if.sv
// Handshake bundle between the feeder, its upstream producer and the MMT engine.
// The slave side is the feeder; the master side drives streams/commands and the MMT result flag.
interface mmt_feeder_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;

   logic       cmd_valid;
   logic [1:0] cmd_mode;
   logic [4:0] cmd_idx_a;
   logic [4:0] cmd_idx_b;
   logic [4:0] cmd_idx_c;
   logic       cmd_ready;

   logic       in_valid;
   logic [7:0] matrix;
   logic [1:0] matrix_size;
   logic       in_valid2;
   logic [4:0] matrix_idx;
   logic [1:0] mode;
   logic       out_valid;

   modport master (
      output s_valid, s_data, cmd_valid, cmd_mode, cmd_idx_a, cmd_idx_b, cmd_idx_c, out_valid,
      input  s_ready, cmd_ready, in_valid, matrix, matrix_size, in_valid2, matrix_idx, mode
   );

   modport slave (
      input  s_valid, s_data, cmd_valid, cmd_mode, cmd_idx_a, cmd_idx_b, cmd_idx_c, out_valid,
      output s_ready, cmd_ready, in_valid, matrix, matrix_size, in_valid2, matrix_idx, mode
   );
endinterface

// File: rtl/mmt_feeder.sv
// Feeds a matrix-load stream and then compute commands into an MMT engine.
// Every output is a flop; handshake readies are registered from the next state.
module mmt_feeder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] cfg_size,
   mmt_feeder_if.slave bus,
   output logic       busy,
   output logic       err,
   output logic [7:0] res_count
);

   typedef enum logic [2:0] {IDLE, LOAD, CMD_WAIT, ISSUE, WAIT_RES} state_e;

   state_e      state_q, state_d;
   logic [1:0]  size_q, size_d;
   logic [11:0] cnt_q, cnt_d;
   logic [11:0] last_idx;
   logic        err_q, err_d;
   logic [7:0]  res_q, res_d;
   logic        seen_q, seen_d;
   logic [1:0]  iss_q, iss_d;
   logic [4:0]  idx_b_q, idx_b_d;
   logic [4:0]  idx_c_q, idx_c_d;

   logic        s_ready_q, s_ready_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        busy_q, busy_d;
   logic        in_valid_q, in_valid_d;
   logic [7:0]  matrix_q, matrix_d;
   logic [1:0]  msize_q, msize_d;
   logic        in_valid2_q, in_valid2_d;
   logic [4:0]  midx_q, midx_d;
   logic [1:0]  mode_q, mode_d;

   // Index of the final element: 16*N*N - 1
   always_comb begin
      last_idx = 12'd63;
      case (size_q)
         2'd0: last_idx = 12'd63;
         2'd1: last_idx = 12'd255;
         2'd2: last_idx = 12'd1023;
         2'd3: last_idx = 12'd4095;
         default: last_idx = 12'd63;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      res_d       = res_q;
      seen_d      = seen_q;
      iss_d       = iss_q;
      idx_b_d     = idx_b_q;
      idx_c_d     = idx_c_q;
      in_valid_d  = 1'b0;
      matrix_d    = 8'd0;
      msize_d     = 2'd0;
      in_valid2_d = 1'b0;
      midx_d      = 5'd0;
      mode_d      = 2'd0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               size_d  = cfg_size;
               cnt_d   = 12'd0;
               err_d   = 1'b0;
               res_d   = 8'd0;
            end
         end

         LOAD: begin
            if (bus.s_valid && s_ready_q) begin
               in_valid_d = 1'b1;
               matrix_d   = bus.s_data;
               msize_d    = (cnt_q == 12'd0) ? size_q : 2'd0;
               cnt_d      = cnt_q + 12'd1;
               if (cnt_q == last_idx)
                  state_d = CMD_WAIT;
            end else if (cnt_q != 12'd0) begin
               // Stream stalled mid-matrix: the engine cannot tolerate gaps
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end

         CMD_WAIT: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               state_d     = ISSUE;
               idx_b_d     = bus.cmd_idx_b;
               idx_c_d     = bus.cmd_idx_c;
               in_valid2_d = 1'b1;
               midx_d      = bus.cmd_idx_a;
               mode_d      = bus.cmd_mode;
               iss_d       = 2'd1;
            end else if (start) begin
               state_d = IDLE;
            end
         end

         ISSUE: begin
            in_valid2_d = 1'b1;
            if (iss_q == 2'd1) begin
               midx_d = idx_b_q;
               iss_d  = 2'd2;
            end else begin
               midx_d  = idx_c_q;
               iss_d   = 2'd0;
               seen_d  = 1'b0;
               state_d = WAIT_RES;
            end
         end

         WAIT_RES: begin
            // Result is done on the falling edge of out_valid
            if (bus.out_valid) begin
               seen_d = 1'b1;
            end else if (seen_q) begin
               seen_d  = 1'b0;
               res_d   = res_q + 8'd1;
               state_d = CMD_WAIT;
            end
         end

         default: state_d = IDLE;
      endcase

      s_ready_d   = (state_d == LOAD);
      cmd_ready_d = (state_d == CMD_WAIT);
      busy_d      = (state_d == LOAD) || (state_d == ISSUE) || (state_d == WAIT_RES);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         size_q      <= 2'd0;
         cnt_q       <= 12'd0;
         err_q       <= 1'b0;
         res_q       <= 8'd0;
         seen_q      <= 1'b0;
         iss_q       <= 2'd0;
         idx_b_q     <= 5'd0;
         idx_c_q     <= 5'd0;
         s_ready_q   <= 1'b0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         in_valid_q  <= 1'b0;
         matrix_q    <= 8'd0;
         msize_q     <= 2'd0;
         in_valid2_q <= 1'b0;
         midx_q      <= 5'd0;
         mode_q      <= 2'd0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         res_q       <= res_d;
         seen_q      <= seen_d;
         iss_q       <= iss_d;
         idx_b_q     <= idx_b_d;
         idx_c_q     <= idx_c_d;
         s_ready_q   <= s_ready_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         in_valid_q  <= in_valid_d;
         matrix_q    <= matrix_d;
         msize_q     <= msize_d;
         in_valid2_q <= in_valid2_d;
         midx_q      <= midx_d;
         mode_q      <= mode_d;
      end
   end

   assign bus.s_ready     = s_ready_q;
   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.in_valid    = in_valid_q;
   assign bus.matrix      = matrix_q;
   assign bus.matrix_size = msize_q;
   assign bus.in_valid2   = in_valid2_q;
   assign bus.matrix_idx  = midx_q;
   assign bus.mode        = mode_q;
   assign busy            = busy_q;
   assign err             = err_q;
   assign res_count       = res_q;

endmodule

// File: tb/tb_mmt_feeder.sv
// Directed bench for mmt_feeder: loads, gap abort, command rounds, counter wrap, reset mid-issue.
module tb_mmt_feeder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [1:0] cfg_size = 2'd0;
   logic       busy, err;
   logic [7:0] res_count;

   int n_chk = 0;
   int n_err = 0;
   int both_cnt = 0;

   mmt_feeder_if bus();

   mmt_feeder dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .cfg_size(cfg_size),
      .bus(bus),
      .busy(busy),
      .err(err),
      .res_count(res_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.in_valid === 1'b1 && bus.in_valid2 === 1'b1) both_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] sz, input int n, input int pre, input bit gap);
      int good;
      int bad_sz;
      int idle_bad;
      logic [7:0] d;
      good = 0; bad_sz = 0; idle_bad = 0;
      start = 1'b1; cfg_size = sz;
      step();
      start = 1'b0;
      check("load_busy", busy, 1);
      check("load_sready", bus.s_ready, 1);
      check("load_err_clr", err, 0);
      check("load_res_clr", res_count, 0);
      for (int i = 0; i < pre; i++) begin
         bus.s_valid = 1'b0;
         step();
         if (bus.in_valid !== 1'b0 || bus.s_ready !== 1'b1) idle_bad++;
      end
      check("pre_idle", idle_bad, 0);
      for (int i = 0; i < n; i++) begin
         d = i[7:0];
         bus.s_valid = 1'b1; bus.s_data = d;
         step();
         if (bus.in_valid === 1'b1 && bus.matrix === d) good++;
         if (i == 0) check("msize_first", bus.matrix_size, sz);
         else if (bus.matrix_size !== 2'd0) bad_sz++;
      end
      bus.s_valid = 1'b0; bus.s_data = 8'd0;
      check("load_cnt", good, n);
      check("msize_rest", bad_sz, 0);
      if (gap) begin
         step();
         check("gap_inv", bus.in_valid, 0);
         check("gap_err", err, 1);
         check("gap_sready", bus.s_ready, 0);
         check("gap_busy", busy, 0);
         check("gap_cready", bus.cmd_ready, 0);
      end else begin
         check("done_sready", bus.s_ready, 0);
         check("done_cready", bus.cmd_ready, 1);
         check("done_err", err, 0);
         check("done_busy", busy, 0);
         step();
         check("done_inv", bus.in_valid, 0);
      end
   endtask

   task automatic cmd_round(input logic [1:0] m, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input int plen, input bit poke_start);
      bus.cmd_valid = 1'b1; bus.cmd_mode = m;
      bus.cmd_idx_a = a; bus.cmd_idx_b = b; bus.cmd_idx_c = c;
      step();
      bus.cmd_valid = 1'b0; bus.cmd_mode = 2'd0;
      bus.cmd_idx_a = 5'd0; bus.cmd_idx_b = 5'd0; bus.cmd_idx_c = 5'd0;
      check("iss0_v", bus.in_valid2, 1);
      check("iss0_idx", bus.matrix_idx, a);
      check("iss0_mode", bus.mode, m);
      check("iss0_cready", bus.cmd_ready, 0);
      check("iss0_busy", busy, 1);
      step();
      check("iss1_v", bus.in_valid2, 1);
      check("iss1_idx", bus.matrix_idx, b);
      check("iss1_mode", bus.mode, 0);
      step();
      check("iss2_v", bus.in_valid2, 1);
      check("iss2_idx", bus.matrix_idx, c);
      check("iss2_mode", bus.mode, 0);
      step();
      check("iss_end", bus.in_valid2, 0);
      for (int p = 0; p < plen; p++) begin
         bus.out_valid = 1'b1;
         start = poke_start;
         step();
         check("wait_busy", busy, 1);
      end
      bus.out_valid = 1'b0;
      start = 1'b0;
      step();
      check("res_cready", bus.cmd_ready, 1);
      check("res_busy", busy, 0);
   endtask

   initial begin
      int idle_v;
      bus.s_valid = 1'b0; bus.s_data = 8'd0;
      bus.cmd_valid = 1'b0; bus.cmd_mode = 2'd0;
      bus.cmd_idx_a = 5'd0; bus.cmd_idx_b = 5'd0; bus.cmd_idx_c = 5'd0;
      bus.out_valid = 1'b0;

      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_res", res_count, 0);
      check("rst_sready", bus.s_ready, 0);
      check("rst_cready", bus.cmd_ready, 0);
      check("rst_inv", bus.in_valid, 0);
      check("rst_inv2", bus.in_valid2, 0);
      step();
      rst_n = 1'b1;
      step();

      // 2x2: 64 contiguous bytes, then a single command round
      load(2'd0, 64, 0, 1'b0);
      cmd_round(2'd2, 5'd3, 5'd7, 5'd15, 4, 1'b0);
      check("res_first", res_count, 1);

      // start in CMD_WAIT without a command drops back to IDLE
      start = 1'b1;
      step();
      check("cw_start_cready", bus.cmd_ready, 0);
      check("cw_start_busy", busy, 0);

      // 4x4 with a gap after element 10, then a clean 16x16 load clears err
      load(2'd1, 10, 0, 1'b1);
      check("gap_res_clr", res_count, 0);
      load(2'd3, 4096, 5, 1'b0);

      // 256 rounds wrap the result counter; start during WAIT_RES is ignored
      for (int r = 0; r < 256; r++) begin
         cmd_round(r[1:0], r[4:0], 5'(~r), 5'(r + 1), 2, 1'b1);
         if (r == 0)   check("res_r0", res_count, 1);
         if (r == 254) check("res_r254", res_count, 255);
      end
      check("res_wrap", res_count, 0);
      cmd_round(2'd1, 5'd1, 5'd2, 5'd3, 1, 1'b0);
      check("res_after_wrap", res_count, 1);

      // Reset in the second ISSUE cycle truncates the command
      bus.cmd_valid = 1'b1; bus.cmd_mode = 2'd3;
      bus.cmd_idx_a = 5'd9; bus.cmd_idx_b = 5'd10; bus.cmd_idx_c = 5'd11;
      step();
      bus.cmd_valid = 1'b0;
      check("ri_idx0", bus.matrix_idx, 9);
      step();
      check("ri_idx1", bus.matrix_idx, 10);
      rst_n = 1'b0;
      #1;
      check("ri_inv2", bus.in_valid2, 0);
      check("ri_idx", bus.matrix_idx, 0);
      check("ri_mode", bus.mode, 0);
      check("ri_busy", busy, 0);
      check("ri_res", res_count, 0);
      check("ri_cready", bus.cmd_ready, 0);
      step();
      rst_n = 1'b1;
      idle_v = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (bus.in_valid2 !== 1'b0 || bus.in_valid !== 1'b0) idle_v++;
      end
      check("ri_no_more", idle_v, 0);
      check("ri_res_after", res_count, 0);
      check("ri_idle_cready", bus.cmd_ready, 0);

      check("never_both", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
